// File: rtl/ysyx_22041211_ifu_pkg.sv
// Shared types and constants for the ysyx_22041211 instruction fetch unit.
package ysyx_22041211_ifu_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [1:0]  RESP_OKAY    = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_OUT  = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ysyx_22041211_ifu_if.sv
// IFU bus bundle: instruction read channel, decoder handshake and redirect port.
interface ysyx_22041211_ifu_if;
  logic [31:0] araddr_o;
  logic        arvalid_o;
  logic        arready_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rvalid_i;
  logic        rready_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        fault_o;
  logic        valid_o;
  logic        ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  modport master (
    output araddr_o, arvalid_o, rready_o, inst_o, pc_o, fault_o, valid_o,
    input  arready_i, rdata_i, rresp_i, rvalid_i, ready_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  araddr_o, arvalid_o, rready_o, inst_o, pc_o, fault_o, valid_o,
    output arready_i, rdata_i, rresp_i, rvalid_i, ready_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/ysyx_22041211_pc_reg.sv
// Architectural fetch PC: loads on redirect, otherwise advances by 4 on accept.
module ysyx_22041211_pc_reg
  import ysyx_22041211_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] load_pc_i,
  input  logic        inc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;

  // Redirect has priority over the increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (load_i) begin
      pc_q <= load_pc_i;
    end else if (inc_i) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ysyx_22041211_ifu.sv
// Instruction fetch unit: single outstanding read, registered outputs, redirect squash.
module ysyx_22041211_ifu
  import ysyx_22041211_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_22041211_ifu_if.master         bus
);

  ifu_state_e  state_q;
  logic [31:0] req_addr_q;
  logic        drop_q;
  logic [31:0] inst_q;
  logic [31:0] pc_out_q;
  logic        fault_q;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        accept;

  assign accept   = (state_q == ST_OUT) && bus.ready_i && !bus.redirect_i;
  assign pc_plus4 = pc + 32'd4;

  ysyx_22041211_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .load_i    (bus.redirect_i),
    .load_pc_i (bus.redirect_pc_i),
    .inc_i     (accept),
    .pc_o      (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_addr_q <= RESET_PC;
      drop_q     <= 1'b0;
      inst_q     <= '0;
      pc_out_q   <= '0;
      fault_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          req_addr_q <= pc;
          state_q    <= ST_ADDR;
          if (bus.redirect_i) drop_q <= 1'b1;
        end
        ST_ADDR: begin
          if (bus.redirect_i) drop_q <= 1'b1;
          if (bus.arready_i)  state_q <= ST_DATA;
        end
        ST_DATA: begin
          // A redirect coinciding with the response squashes it directly,
          // so the flag never needs setting for that beat.
          if (bus.rvalid_i) begin
            if (bus.redirect_i) begin
              drop_q     <= 1'b0;
              req_addr_q <= bus.redirect_pc_i;
              state_q    <= ST_ADDR;
            end else if (drop_q) begin
              drop_q     <= 1'b0;
              req_addr_q <= pc;
              state_q    <= ST_ADDR;
            end else begin
              inst_q   <= bus.rdata_i;
              pc_out_q <= req_addr_q;
              fault_q  <= (bus.rresp_i != RESP_OKAY);
              state_q  <= ST_OUT;
            end
          end else if (bus.redirect_i) begin
            drop_q <= 1'b1;
          end
        end
        ST_OUT: begin
          if (bus.redirect_i) begin
            req_addr_q <= bus.redirect_pc_i;
            state_q    <= ST_ADDR;
          end else if (bus.ready_i) begin
            req_addr_q <= pc_plus4;
            state_q    <= ST_ADDR;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.araddr_o  = req_addr_q;
  assign bus.arvalid_o = (state_q == ST_ADDR);
  assign bus.rready_o  = (state_q == ST_DATA);
  assign bus.valid_o   = (state_q == ST_OUT);
  assign bus.inst_o    = inst_q;
  assign bus.pc_o      = pc_out_q;
  assign bus.fault_o   = fault_q;

endmodule
